rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 32-entry register file between NREQ requesters.
- Selects one requester per cycle and registers its write data and 5-bit address.
- Decodes the address to a one-hot 32-bit write-enable vector, using the 5-to-32 scheme: upper 2 bits select a bank of 8, lower 3 bits select the entry.
- Sits between the execution/load units and the register-file array; the array consumes wr_en/wr_data directly.

Parameters:
- NREQ, 4: number of requesters; supported range 2..8.
- DW, 32: write data width.
- ZERO_LOCK, 1: when 1, register 0 is hardwired; a write to address 0 is granted but produces no enable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global arbiter enable; low means no grants.
- req  in  NREQ  per-requester write request, level.
- req_addr  in  NREQ*5  requester i address at bits [5i+4:5i].
- req_data  in  NREQ*DW  requester i data at bits [DW*i+DW-1:DW*i].
- gnt  out  NREQ  one-hot grant pulse, registered.
- wr_en  out  32  one-hot decoded write enable to the register file, registered.
- wr_addr  out  5  granted address, registered.
- wr_data  out  DW  granted data, registered.
- wr_valid  out  1  a write was granted this cycle, registered.

Behaviour:
- Reset:
  - At a rising edge with rst=1: gnt, wr_en, wr_addr, wr_data and wr_valid are set to 0; the round-robin pointer ptr is set to 0.
  - Requests present at that edge are ignored.
  - rst has priority over en and req.
- Eligibility at each edge with rst=0:
  - eligible = req & ~gnt. The requester granted in the current cycle is masked, so a requester holding req high for one extra cycle is not double-granted.
  - Any one requester is granted at most every other cycle.
- Selection:
  - If en=1 and eligible≠0, the winner w is the first eligible index scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (wrap-around).
- Grant update at the edge:
  - gnt ← one-hot(w); wr_valid ← 1.
  - wr_addr ← req_addr[w]; wr_data ← req_data[w].
  - wr_en ← decode(req_addr[w]): bit a=1, all others 0.
  - ptr ← (w+1) mod NREQ.
- Zero address: if ZERO_LOCK=1 and req_addr[w]=0, wr_en ← 0 while gnt, wr_valid and wr_addr are still updated. The request is consumed.
- No grant (en=0 or eligible=0):
  - gnt, wr_en and wr_valid ← 0; ptr holds.
  - wr_addr and wr_data hold their previous values (don't-care).
- Latency: a request sampled at edge t appears as gnt/wr_en during cycle t..t+1, one cycle.
- Requester handshake: keep req, req_addr and req_data stable until gnt[i] is observed high. At the edge ending the gnt cycle, either drop req or present the next request.
- Invariants:
  - gnt and wr_en are each one-hot or zero.
  - popcount(wr_en) ≤ wr_valid.
  - wr_en is zero whenever wr_valid=0.
- en deasserted mid-stream: pending requests wait; on re-enable, arbitration resumes from the held ptr.
- Reset mid-operation: an in-flight grant is dropped (outputs 0 the following cycle). Requesters must re-request; holding req satisfies this.
- No combinational path from req/req_addr/req_data to any output.

Test Plan:
- Reset: assert rst with req=4'b1111 for 2 edges -> gnt=0, wr_en=0, wr_valid=0; first grant after release goes to requester 0.
- Single requester: req=4'b0100, addr2=5'd13, data2=32'hDEADBEEF held -> next cycle gnt=4'b0100, wr_en=32'h0000_2000, wr_data=32'hDEADBEEF. Following cycle gnt=0 (masked); regranted the cycle after if still held.
- Round-robin fairness and wrap: req=4'b1111 held continuously from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001. No requester is granted twice consecutively.
- Pointer skip: ptr=2 after a grant to requester 1, req=4'b1001 -> gnt=4'b1000, then 4'b0001.
- Zero lock: requester 1 with addr=0, data=32'h1234 -> gnt=4'b0010, wr_valid=1, wr_addr=0, wr_en=0. Address 5'd31 -> wr_en=32'h8000_0000.
- Enable/reset interplay: en=0 with req=4'b0011 for 3 cycles -> no grants and ptr unchanged; en=1 -> gnt=4'b0001. rst pulsed during a grant cycle -> all outputs 0 next cycle, ptr=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single write port of a 32-entry register file.
// Registers the winning address and data, and decodes the address into a one-hot write enable.
module rf_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int ZERO_LOCK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*5-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [31:0]       wr_en,
    output logic [4:0]        wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              wr_valid
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [31:0]     wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            wr_valid_q, wr_valid_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   winner;
    logic            found;
    logic            doGrant;
    logic [4:0]      selAddr;
    logic [DW-1:0]   selData;

    // Upper two address bits pick a bank of eight, lower three pick the entry within it.
    function automatic logic [31:0] decodeAddr(input logic [4:0] a);
        logic [3:0]  bank;
        logic [7:0]  entry;
        logic [31:0] oneHot;
        bank   = 4'b0001 << a[4:3];
        entry  = 8'b0000_0001 << a[2:0];
        oneHot = '0;
        for (int b = 0; b < 4; b++) begin
            for (int e = 0; e < 8; e++) begin
                oneHot[b*8+e] = bank[b] & entry[e];
            end
        end
        return oneHot;
    endfunction

    // The requester granted this cycle is masked, so a held req cannot win twice in a row.
    assign eligible = req & ~gnt_q;

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign doGrant = en & found;
    assign selAddr = req_addr[int'(winner)*5 +: 5];
    assign selData = req_data[int'(winner)*DW +: DW];

    always_comb begin
        gnt_d      = '0;
        wr_en_d    = '0;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ptr_d      = ptr_q;
        if (doGrant) begin
            gnt_d[winner] = 1'b1;
            wr_valid_d    = 1'b1;
            wr_addr_d     = selAddr;
            wr_data_d     = selData;
            // A write to register 0 is still consumed, it just never reaches the array.
            if ((ZERO_LOCK != 0) && (selAddr == 5'd0)) begin
                wr_en_d = '0;
            end else begin
                wr_en_d = decodeAddr(selAddr);
            end
            if (winner == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed plan steps, then randomized handshaking
// requesters compared against a queue-free round-robin reference model.
module tb_rf_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ*5-1:0] reqAddrBus;
    logic [NREQ*DW-1:0] reqDataBus;
    logic [NREQ-1:0]   gnt;
    logic [31:0]       wr_en;
    logic [4:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;

    logic [4:0]  reqAddrArr [NREQ];
    logic [31:0] reqDataArr [NREQ];

    int          mPtr;
    logic [3:0]  mGnt;
    logic [31:0] mWrEn;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic        mValid;

    int tests  = 0;
    int failed = 0;

    rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .ZERO_LOCK(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .req_addr (reqAddrBus),
        .req_data (reqDataBus),
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        reqAddrBus = '0;
        reqDataBus = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqAddrBus[5*i +: 5]   = reqAddrArr[i];
            reqDataBus[DW*i +: DW] = reqDataArr[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check("gnt", 32'(gnt), 32'(mGnt));
        check("wr_en", wr_en, mWrEn);
        check("wr_addr", 32'(wr_addr), 32'(mAddr));
        check("wr_data", wr_data, mData);
        check("wr_valid", 32'(wr_valid), 32'(mValid));
        check("onehot_inv", 32'(($countones(wr_en) <= int'(wr_valid)) && ($countones(gnt) <= 1)), 32'd1);
    endtask

    // Reference: pick the first requesting, not-just-granted index going round from the pointer.
    task automatic applyStimulus();
        logic [3:0] elig;
        int w;
        int idx;
        w    = -1;
        elig = req & ~mGnt;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mPtr + k) % NREQ;
                if (w < 0 && elig[idx]) w = idx;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mGnt = '0; mWrEn = '0; mAddr = '0; mData = '0; mValid = 1'b0; mPtr = 0;
        end else if (w >= 0) begin
            mGnt   = 4'b0001 << w;
            mValid = 1'b1;
            mAddr  = reqAddrArr[w];
            mData  = reqDataArr[w];
            mWrEn  = (mAddr == 5'd0) ? 32'd0 : (32'd1 << mAddr);
            mPtr   = (w + 1) % NREQ;
        end else begin
            mGnt = '0; mWrEn = '0; mValid = 1'b0;
        end
        checkOutput();
    endtask

    initial begin
        logic [3:0] expSeq [5];
        expSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mPtr = 0; mGnt = '0; mWrEn = '0; mAddr = '0; mData = '0; mValid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            reqAddrArr[i] = 5'(i + 1);
            reqDataArr[i] = $urandom;
        end

        rst = 1'b1; en = 1'b1; req = 4'b1111;
        applyStimulus();
        applyStimulus();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_valid", 32'(wr_valid), 32'd0);

        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            applyStimulus();
            check("rr_seq", 32'(gnt), 32'(expSeq[s]));
        end

        req = 4'b0100; reqAddrArr[2] = 5'd13; reqDataArr[2] = 32'hDEADBEEF;
        applyStimulus();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_wren", wr_en, 32'h0000_2000);
        check("single_data", wr_data, 32'hDEADBEEF);
        applyStimulus();
        check("single_masked", 32'(gnt), 32'h0);
        applyStimulus();
        check("single_regrant", 32'(gnt), 32'h4);

        req = 4'b0010;
        applyStimulus();
        check("skip_prep", 32'(gnt), 32'h2);
        req = 4'b1001;
        applyStimulus();
        check("skip_first", 32'(gnt), 32'h8);
        applyStimulus();
        check("skip_wrap", 32'(gnt), 32'h1);

        req = 4'b0010; reqAddrArr[1] = 5'd0; reqDataArr[1] = 32'h1234;
        applyStimulus();
        check("zero_gnt", 32'(gnt), 32'h2);
        check("zero_valid", 32'(wr_valid), 32'd1);
        check("zero_wren", wr_en, 32'd0);
        reqAddrArr[1] = 5'd31;
        applyStimulus();
        applyStimulus();
        check("addr31_wren", wr_en, 32'h8000_0000);

        req = 4'b0011; en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            applyStimulus();
            check("en_off_gnt", 32'(gnt), 32'd0);
        end
        en = 1'b1;
        applyStimulus();
        check("en_resume", 32'(gnt), 32'h1);
        rst = 1'b1;
        applyStimulus();
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_wren", wr_en, 32'd0);
        rst = 1'b0;
        applyStimulus();
        check("midrst_ptr0", 32'(gnt), 32'h1);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mGnt[i] || !req[i]) begin
                    req[i] = ($urandom % 3) != 0;
                    reqAddrArr[i] = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom);
                    reqDataArr[i] = $urandom;
                end
            end
            en  = ($urandom % 8) != 0;
            rst = ($urandom % 64) == 0;
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
